// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo: buffered UART loopback; RX words are queued in a FIFO and
// replayed to the transmitter one at a time via a send_en / tx_busy handshake.
// Latency: recv_done rise -> word in FIFO after 2 clocks -> send_en 4 clocks
//   after the rise when the transmitter is idle.
// Backpressure: words wait in the FIFO while tx_busy is high; a word that
//   arrives while the FIFO is full (and nothing is popped that cycle) is
//   dropped and sets the sticky overflow flag.
// Optional feature: define UART_LOOP_UPCASE_EN to upper-case ASCII 'a'..'z'
//   in the low byte of each word as it is loaded into send_data.
//
// Ports:
//   sys_clk, sys_rst    clock, asynchronous active-high reset
//   recv_done/recv_data RX word strobe (rising edge captured) and data
//   tx_busy             transmitter busy
//   clr_overflow        synchronous clear of the sticky overflow flag
//   send_en/send_data   1-cycle start pulse and word to transmit
//   fifo_count          FIFO occupancy 0..2**DEPTH_LOG2
//   overflow            sticky dropped-word flag
//   activity            FSM busy or FIFO non-empty (registered, LED drive)
module uart_loop_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int HOLD_CYC   = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  recv_done,
  input  logic [DATA_W-1:0]     recv_data,
  input  logic                  tx_busy,
  input  logic                  clr_overflow,
  output logic                  send_en,
  output logic [DATA_W-1:0]     send_data,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  activity
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [7:0]          HOLD_LAST = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   send_en_q;
  logic [DATA_W-1:0]      send_data_q;
  logic [7:0]             hold_cnt_q;

  logic                   d0_q, d1_q;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   activity_q;

  logic                   push, pop, full, wr_acc, ovf_set;
  logic [DATA_W-1:0]      head;

  // Word transform applied on the way into send_data.
  function automatic logic [DATA_W-1:0] tx_xform(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = w;
`ifdef UART_LOOP_UPCASE_EN
    if (w[7:0] >= 8'h61 && w[7:0] <= 8'h7A) begin
      r[7:0] = w[7:0] - 8'h20;
    end
`else
`endif
    return r;
  endfunction

  // Rising-edge detect: a level-held recv_done produces a single push.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      d0_q <= 1'b0;
      d1_q <= 1'b0;
    end else begin
      d0_q <= recv_done;
      d1_q <= d0_q;
    end
  end

  assign push = d0_q & ~d1_q;
  assign pop  = (state_q == SEND);
  assign full = (count_q == FULL_CNT);
  // When full, a same-cycle pop frees the slot being written, so accept.
  assign wr_acc  = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    if (wr_acc && !pop) begin
      count_d = count_q + (DEPTH_LOG2+1)'(1);
    end else if (!wr_acc && pop) begin
      count_d = count_q - (DEPTH_LOG2+1)'(1);
    end
    // Setting wins over a simultaneous clear so no drop goes unreported.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      activity_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      activity_q <= (state_q != IDLE) | (count_q != '0);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge sys_clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= recv_data;
    end
  end

  // TX handshake FSM. HOLD waits a bounded time for tx_busy; if the
  // transmitter never acknowledges, the word is treated as sent.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      send_en_q   <= 1'b0;
      send_data_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      send_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (count_q != '0 && !tx_busy) begin
            state_q <= SEND;
          end
        end
        SEND: begin
          send_data_q <= tx_xform(head);
          send_en_q   <= 1'b1;
          hold_cnt_q  <= '0;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (tx_busy) begin
            state_q <= DRAIN;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign send_en    = send_en_q;
  assign send_data  = send_data_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign activity   = activity_q;

endmodule

// File: doc/uart_loop_fifo.md
Name: uart_loop_fifo

Overview:
Buffered UART loopback, successor to the single-byte loop block. Captures each received word on the rising edge of recv_done into a parametrised FIFO. Replays words to the UART transmitter through a send_en/tx_busy handshake FSM. Adds word-width and depth parameters, a sticky overflow flag and an occupancy count, so back-to-back RX bursts no longer lose data while TX is busy.

Parameters:
DATA_W, 8, width of recv_data/send_data and FIFO entries
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (legal 1..8)
HOLD_CYC, 4, max cycles after send_en to wait for tx_busy to assert (legal 1..255)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  asynchronous active-high reset
recv_done  in  1  RX word-complete level/pulse from UART receiver (sys_clk domain)
recv_data  in  DATA_W  RX word, valid while recv_done high
tx_busy  in  1  UART transmitter busy
clr_overflow  in  1  synchronous clear of overflow (1-cycle pulse)
send_en  out  1  1-cycle pulse: start transmission of send_data
send_data  out  DATA_W  word to transmit, stable from send_en until the next send_en
fifo_count  out  DEPTH_LOG2+1  current occupancy 0..2**DEPTH_LOG2
overflow  out  1  sticky: a received word was dropped because the FIFO was full
activity  out  1  high while FSM not IDLE or FIFO not empty (LED drive)

Behaviour:
- Reset (async, sys_rst=1): send_en=0, send_data=0, fifo_count=0, overflow=0, activity=0, edge registers=0, FSM=IDLE, rd/wr pointers=0.
- Edge detect: d0<=recv_done, d1<=d0; push = d0 & ~d1. recv_data is sampled in the push cycle. A word therefore enters the FIFO 2 cycles after recv_done rises. Level-held recv_done yields exactly one push.
- Push when not full: mem[wr_ptr]<=data, wr_ptr+1 (wraps modulo depth), count+1.
- Push when full with no pop in the same cycle: word dropped, overflow<=1, pointers/count unchanged.
- Push and pop in the same cycle: both are performed and count is unchanged; this holds when full (push accepted) and when count=1.
- Pop with empty FIFO never occurs; the FSM only leaves IDLE when count!=0.
- overflow: set takes priority over clr_overflow in the same cycle.
- TX FSM states:
  - IDLE: if count!=0 and tx_busy=0, go to SEND.
  - SEND (one cycle): send_data<=head word, send_en<=1, pop; go to HOLD and clear the hold counter. send_en is 1 only during the cycle following SEND entry (registered).
  - HOLD: if tx_busy=1, go to DRAIN; else if hold counter reaches HOLD_CYC-1, go to IDLE (TX missed the start; word is considered sent, no retry); else increment.
  - DRAIN: if tx_busy=0, go to IDLE.
- Throughput: minimum spacing between send_en pulses = TX frame time + 2 cycles.
- activity = (state!=IDLE) | (count!=0), registered.
- Reset mid-transfer: FIFO contents lost, send_en is forced low immediately.

Optional Feature:
UART_LOOP_UPCASE_EN: when defined, the low 8 bits of each word are converted from ASCII 'a'..'z' (0x61..0x7A) to upper case (subtract 0x20) as the word is loaded into send_data; other values and upper bits are unchanged; no added latency. When undefined, words are echoed verbatim.

Test Plan:
- Single word: recv_data=0x41, recv_done high 3 cycles, tx_busy idle -> exactly one push; send_en pulse with send_data=0x41 four cycles after recv_done rise; fifo_count 0->1->0.
- Burst while busy: tx_busy held 1, 5 words 0x10..0x14 -> fifo_count=5, no send_en; release tx_busy -> sends 0x10..0x14 in order, each after the prior tx_busy fall.
- Overflow: DEPTH_LOG2=2, tx_busy=1, 6 words -> count=4, overflow=1, words 5-6 dropped; clr_overflow pulse -> overflow=0; drain yields the first 4 words only.
- Full with simultaneous push and pop: count=4, tx_busy falls on the cycle a push occurs -> count stays 4, no overflow, the new word is sent last.
- HOLD timeout: tx_busy never asserts, HOLD_CYC=4 -> FSM returns to IDLE 4 cycles after SEND; the next word is sent; no deadlock.
- Upcase (macro defined): receive 0x61, 0x7A, 0x5B -> send 0x41, 0x5A, 0x5B; undefined -> 0x61, 0x7A, 0x5B. Async reset mid-DRAIN -> all outputs 0 within the reset assertion.
